// File: rtl/alu_issue_sched_pkg.sv
// Shared types for the ALU issue scheduler: micro-op layout, scheduler entry
// layout and the operand-source helper used at dispatch.
package alu_issue_sched_pkg;

  localparam int XLEN    = 32;
  localparam int PHYS_W  = 6;
  localparam int ROB_W   = 5;
  localparam int EPOCH_W = 2;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_RS1 = 2'd0,
    SRC_RS2 = 2'd1,
    SRC_IMM = 2'd2,
    SRC_PC  = 2'd3
  } src_sel_e;

  // Decoded ALU bundle produced by the decoder.
  typedef struct packed {
    alu_op_e         op;
    logic            uses_rs1;
    logic            uses_rs2;
    src_sel_e        src1_select;
    src_sel_e        src2_select;
    logic [XLEN-1:0] imm;
  } alu_bundle_t;

  // Renamed micro-op as handed over by rename/dispatch.
  typedef struct packed {
    alu_bundle_t        bundle;
    logic [ROB_W-1:0]   rob_idx;
    logic [EPOCH_W-1:0] epoch;
    logic [PHYS_W-1:0]  prd_new;
    logic [PHYS_W-1:0]  prs1;
    logic [PHYS_W-1:0]  prs2;
  } rs_uop_t;

  // One scheduler slot: the uop plus captured operand values.
  typedef struct packed {
    logic            valid;
    rs_uop_t         uop;
    logic            rdy1;
    logic            rdy2;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
  } sched_entry_t;

  // An operand needs a physical register value only when it is used and the
  // source mux actually selects a register.
  function automatic logic src_needs_reg(input logic uses, input src_sel_e sel);
    return uses && ((sel == SRC_RS1) || (sel == SRC_RS2));
  endfunction

endpackage

// File: rtl/alu_issue_sched_pick.sv
// Combinational oldest-first picker. age[i][j]=1 means entry i is older than
// entry j. An entry wins when it requests and no other requester is older.
module alu_issue_sched_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant,
  output logic [IDX_W-1:0]    idx
);

  logic [N-1:0] older;

  // Grant each requester that has no older requester.
  always_comb begin
    grant = '0;
    older = '0;
    for (int i = 0; i < N; i++) begin
      older = '0;
      for (int j = 0; j < N; j++) begin
        older[j] = req[j] && age[j][i] && (j != i);
      end
      grant[i] = req[i] && !(|older);
    end
  end

  // Encode the one-hot grant to an index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Data-capture issue scheduler in front of the single ALU. Buffers up to DEPTH
// micro-ops, captures operands at dispatch or from the wakeup bus, and issues
// the oldest fully ready entry.
//
// Handshakes: a transfer happens at a rising edge where valid && ready are
// both 1. Once iss_valid is raised it stays raised with the same uop and
// operand values until iss_ready is seen (unless reset or a flush kills the
// entry). disp_ready depends only on registered state and flush_valid, never
// on disp_valid.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp_valid,
  output logic               disp_ready,
  input  rs_uop_t            disp_uop,
  input  logic               disp_rs1_rdy,
  input  logic               disp_rs2_rdy,
  input  logic [XLEN-1:0]    disp_rs1_val,
  input  logic [XLEN-1:0]    disp_rs2_val,
  input  logic               wk_valid,
  input  logic [PHYS_W-1:0]  wk_prd,
  input  logic [XLEN-1:0]    wk_data,
  output logic               iss_valid,
  input  logic               iss_ready,
  output rs_uop_t            iss_uop,
  output logic [XLEN-1:0]    iss_rs1_val,
  output logic [XLEN-1:0]    iss_rs2_val,
  input  logic               flush_valid,
  input  logic [EPOCH_W-1:0] flush_epoch,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);

  sched_entry_t               ents   [DEPTH];
  sched_entry_t               ents_n [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_n;
  logic                       lock_q, lock_n;
  logic [IDX_W-1:0]           lock_idx_q, lock_idx_n;
  logic [CNT_W-1:0]           occ_q, occ_n;

  logic [DEPTH-1:0]           valid_vec, req_vec, grant;
  logic [IDX_W-1:0]           pick_idx, sel_idx, free_idx;
  logic                       pick_any;
  logic                       disp_fire, iss_fire;
  logic                       need1, need2;
  sched_entry_t               new_ent;

  // Valid and request vectors straight from entry registers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ents[i].valid;
      req_vec[i]   = ents[i].valid && ents[i].rdy1 && ents[i].rdy2;
    end
  end

  alu_issue_sched_pick #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_vec),
    .age   (age_q),
    .grant (grant),
    .idx   (pick_idx)
  );

  assign pick_any  = |grant;
  assign sel_idx   = lock_q ? lock_idx_q : pick_idx;
  assign iss_valid = lock_q || pick_any;
  assign iss_fire  = iss_valid && iss_ready;

  assign disp_ready = !rst_n && (occ_q < CNT_W'(DEPTH)) && !flush_valid;
  assign disp_fire  = disp_valid && disp_ready;
  assign occupancy  = occ_q;

  // Issue port driven from the selected entry; zero while nothing is offered.
  always_comb begin
    iss_uop     = '0;
    iss_rs1_val = '0;
    iss_rs2_val = '0;
    if (iss_valid) begin
      iss_uop     = ents[sel_idx].uop;
      iss_rs1_val = ents[sel_idx].val1;
      iss_rs2_val = ents[sel_idx].val2;
    end
  end

  // Lowest-index free slot from registered state.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

  assign need1 = src_needs_reg(disp_uop.bundle.uses_rs1, disp_uop.bundle.src1_select);
  assign need2 = src_needs_reg(disp_uop.bundle.uses_rs2, disp_uop.bundle.src2_select);

  // Build the entry written on dispatch, including same-cycle wakeup capture.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.uop   = disp_uop;
    if (!need1 || (disp_uop.prs1 == '0)) begin
      new_ent.rdy1 = 1'b1;
    end else if (disp_rs1_rdy) begin
      new_ent.rdy1 = 1'b1;
      new_ent.val1 = disp_rs1_val;
    end else if (wk_valid && (wk_prd == disp_uop.prs1)) begin
      new_ent.rdy1 = 1'b1;
      new_ent.val1 = wk_data;
    end
    if (!need2 || (disp_uop.prs2 == '0)) begin
      new_ent.rdy2 = 1'b1;
    end else if (disp_rs2_rdy) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = disp_rs2_val;
    end else if (wk_valid && (wk_prd == disp_uop.prs2)) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = wk_data;
    end
  end

  // Next state: wakeup, issue free, flush kill, dispatch allocate, lock, count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ents_n[i] = ents[i];
    age_n      = age_q;
    lock_n     = lock_q;
    lock_idx_n = lock_idx_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (ents[i].valid && wk_valid) begin
        if (!ents[i].rdy1 && (ents[i].uop.prs1 == wk_prd)) begin
          ents_n[i].rdy1 = 1'b1;
          ents_n[i].val1 = wk_data;
        end
        if (!ents[i].rdy2 && (ents[i].uop.prs2 == wk_prd)) begin
          ents_n[i].rdy2 = 1'b1;
          ents_n[i].val2 = wk_data;
        end
      end
    end

    // The ALU already accepted it, so a flush cannot undo the handshake.
    if (iss_fire) ents_n[sel_idx].valid = 1'b0;

    if (flush_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ents[i].uop.epoch != flush_epoch) ents_n[i].valid = 1'b0;
      end
    end

    // New entry is younger than every entry currently holding a slot.
    if (disp_fire) begin
      ents_n[free_idx] = new_ent;
      for (int j = 0; j < DEPTH; j++) begin
        age_n[free_idx][j] = 1'b0;
        age_n[j][free_idx] = ents[j].valid;
      end
    end

    if (iss_fire) begin
      lock_n = 1'b0;
    end else if (iss_valid) begin
      lock_n     = 1'b1;
      lock_idx_n = sel_idx;
    end
    if (lock_n && flush_valid && (ents[lock_idx_n].uop.epoch != flush_epoch)) begin
      lock_n = 1'b0;
    end

    occ_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_n = occ_n + CNT_W'(ents_n[i].valid);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
      age_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      occ_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ents[i] <= ents_n[i];
      age_q      <= age_n;
      lock_q     <= lock_n;
      lock_idx_q <= lock_idx_n;
      occ_q      <= occ_n;
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched.
module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               disp_valid;
  logic               disp_ready;
  rs_uop_t            disp_uop;
  logic               disp_rs1_rdy, disp_rs2_rdy;
  logic [XLEN-1:0]    disp_rs1_val, disp_rs2_val;
  logic               wk_valid;
  logic [PHYS_W-1:0]  wk_prd;
  logic [XLEN-1:0]    wk_data;
  logic               iss_valid;
  logic               iss_ready;
  rs_uop_t            iss_uop;
  logic [XLEN-1:0]    iss_rs1_val, iss_rs2_val;
  logic               flush_valid;
  logic [EPOCH_W-1:0] flush_epoch;
  logic [CNT_W-1:0]   occupancy;

  int checks   = 0;
  int failures = 0;

  alu_issue_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_uop     (disp_uop),
    .disp_rs1_rdy (disp_rs1_rdy),
    .disp_rs2_rdy (disp_rs2_rdy),
    .disp_rs1_val (disp_rs1_val),
    .disp_rs2_val (disp_rs2_val),
    .wk_valid     (wk_valid),
    .wk_prd       (wk_prd),
    .wk_data      (wk_data),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_uop      (iss_uop),
    .iss_rs1_val  (iss_rs1_val),
    .iss_rs2_val  (iss_rs2_val),
    .flush_valid  (flush_valid),
    .flush_epoch  (flush_epoch),
    .occupancy    (occupancy)
  );

  function automatic rs_uop_t mk_uop(input alu_op_e op, input int rob, input int ep,
                                     input int p1, input int p2);
    rs_uop_t u;
    u = '0;
    u.bundle.op          = op;
    u.bundle.uses_rs1    = 1'b1;
    u.bundle.uses_rs2    = 1'b1;
    u.bundle.src1_select = SRC_RS1;
    u.bundle.src2_select = SRC_RS2;
    u.rob_idx = ROB_W'(rob);
    u.epoch   = EPOCH_W'(ep);
    u.prd_new = PHYS_W'(rob);
    u.prs1    = PHYS_W'(p1);
    u.prs2    = PHYS_W'(p2);
    return u;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid   = 1'b0;
    disp_uop     = '0;
    disp_rs1_rdy = 1'b0;
    disp_rs2_rdy = 1'b0;
    disp_rs1_val = '0;
    disp_rs2_val = '0;
    wk_valid     = 1'b0;
    wk_prd       = '0;
    wk_data      = '0;
    flush_valid  = 1'b0;
    flush_epoch  = '0;
  endtask

  task automatic drive_disp(input rs_uop_t u, input logic r1, input int v1,
                            input logic r2, input int v2);
    disp_valid   = 1'b1;
    disp_uop     = u;
    disp_rs1_rdy = r1;
    disp_rs1_val = XLEN'(v1);
    disp_rs2_rdy = r2;
    disp_rs2_val = XLEN'(v2);
  endtask

  task automatic drive_wk(input int tag, input int data);
    wk_valid = 1'b1;
    wk_prd   = PHYS_W'(tag);
    wk_data  = XLEN'(data);
  endtask

  task automatic test_reset();
    idle_inputs();
    iss_ready = 1'b0;
    rst_n = 1'b1;
    #2;
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid: got %0b want 0", iss_valid); end
    checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL reset_disp_ready: got %0b want 0", disp_ready); end
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (iss_uop !== '0) begin failures++; $display("FAIL reset_iss_uop: got %0h want 0", iss_uop); end
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL post_reset_disp_ready: got %0b want 1", disp_ready); end
  endtask

  task automatic test_add();
    logic [XLEN-1:0] res;
    iss_ready = 1'b1;
    drive_disp(mk_uop(ALU_ADD, 1, 0, 5, 6), 1'b1, 100, 1'b1, 50);
    settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL add_no_same_cycle: got %0b want 0", iss_valid); end
    tick();
    idle_inputs();
    settle();
    res = iss_rs1_val + iss_rs2_val;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL add_iss_valid: got %0b want 1", iss_valid); end
    checks++; if (res !== 150) begin failures++; $display("FAIL add_result: got %0d want 150", res); end
    checks++; if (iss_uop.rob_idx !== 1) begin failures++; $display("FAIL add_rob: got %0d want 1", iss_uop.rob_idx); end
    checks++; if (occupancy !== 1) begin failures++; $display("FAIL add_occ1: got %0d want 1", occupancy); end
    tick();
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL add_occ0: got %0d want 0", occupancy); end
  endtask

  task automatic test_wakeup();
    logic [XLEN-1:0] res;
    iss_ready = 1'b1;
    drive_disp(mk_uop(ALU_SUB, 2, 0, 12, 7), 1'b0, 0, 1'b1, 30);
    tick();
    idle_inputs();
    settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL wk_wait1: got %0b want 0", iss_valid); end
    tick();
    drive_wk(12, 100);
    settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL wk_no_bypass: got %0b want 0", iss_valid); end
    tick();
    idle_inputs();
    settle();
    res = iss_rs1_val - iss_rs2_val;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL wk_iss_valid: got %0b want 1", iss_valid); end
    checks++; if (iss_rs1_val !== 100) begin failures++; $display("FAIL wk_rs1: got %0d want 100", iss_rs1_val); end
    checks++; if (res !== 70) begin failures++; $display("FAIL wk_result: got %0d want 70", res); end
    tick();
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL wk_occ0: got %0d want 0", occupancy); end
  endtask

  task automatic test_age();
    iss_ready = 1'b1;
    drive_disp(mk_uop(ALU_ADD, 1, 0, 20, 3), 1'b0, 0, 1'b1, 1);
    tick();
    drive_disp(mk_uop(ALU_ADD, 2, 0, 4, 5), 1'b1, 2, 1'b1, 3);
    settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL age_a_blocked: got %0b want 0", iss_valid); end
    tick();
    idle_inputs();
    drive_wk(20, 7);
    settle();
    checks++; if (iss_uop.rob_idx !== 2) begin failures++; $display("FAIL age_b_first: got %0d want 2", iss_uop.rob_idx); end
    tick();
    idle_inputs();
    settle();
    checks++; if (iss_uop.rob_idx !== 1) begin failures++; $display("FAIL age_a_second: got %0d want 1", iss_uop.rob_idx); end
    checks++; if (iss_rs1_val !== 7) begin failures++; $display("FAIL age_a_rs1: got %0d want 7", iss_rs1_val); end
    tick();
    // Both entries wake on the same tag: the older one must win.
    drive_disp(mk_uop(ALU_OR, 3, 0, 21, 3), 1'b0, 0, 1'b1, 1);
    tick();
    drive_disp(mk_uop(ALU_OR, 4, 0, 21, 3), 1'b0, 0, 1'b1, 1);
    tick();
    idle_inputs();
    drive_wk(21, 9);
    settle();
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL age_cd_blocked: got %0b want 0", iss_valid); end
    tick();
    idle_inputs();
    settle();
    checks++; if (iss_uop.rob_idx !== 3) begin failures++; $display("FAIL age_c_first: got %0d want 3", iss_uop.rob_idx); end
    tick();
    checks++; if (iss_uop.rob_idx !== 4) begin failures++; $display("FAIL age_d_second: got %0d want 4", iss_uop.rob_idx); end
    tick();
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL age_occ0: got %0d want 0", occupancy); end
  endtask

  task automatic test_fill_stall();
    int exp_rob [8];
    exp_rob = '{11, 10, 12, 13, 14, 15, 16, 17};
    iss_ready = 1'b0;
    drive_disp(mk_uop(ALU_ADD, 10, 0, 30, 3), 1'b0, 0, 1'b1, 1);
    tick();
    for (int k = 1; k < 8; k++) begin
      drive_disp(mk_uop(ALU_ADD, 10 + k, 0, 2, 3), 1'b1, 1000 + k, 1'b1, k);
      tick();
    end
    idle_inputs();
    settle();
    checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL fill_disp_ready: got %0b want 0", disp_ready); end
    checks++; if (occupancy !== 8) begin failures++; $display("FAIL fill_occ: got %0d want 8", occupancy); end
    checks++; if (iss_uop.rob_idx !== 11) begin failures++; $display("FAIL fill_locked: got %0d want 11", iss_uop.rob_idx); end
    // Refused dispatch while full plus wakeup of the older blocked entry.
    drive_disp(mk_uop(ALU_ADD, 18, 0, 2, 3), 1'b1, 5, 1'b1, 5);
    drive_wk(30, 77);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (occupancy !== 8) begin failures++; $display("FAIL stall_occ%0d: got %0d want 8", c, occupancy); end
      checks++; if (iss_uop.rob_idx !== 11 || iss_rs1_val !== 1001) begin failures++; $display("FAIL stall_stable%0d: got rob %0d rs1 %0d want rob 11 rs1 1001", c, iss_uop.rob_idx, iss_rs1_val); end
      tick();
    end
    iss_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      checks++; if (iss_valid !== 1'b1 || iss_uop.rob_idx !== ROB_W'(exp_rob[k])) begin failures++; $display("FAIL drain%0d: got v %0b rob %0d want rob %0d", k, iss_valid, iss_uop.rob_idx, exp_rob[k]); end
      tick();
    end
    checks++; if (iss_valid !== 1'b0 || occupancy !== 0) begin failures++; $display("FAIL drain_empty: got v %0b occ %0d want 0 0", iss_valid, occupancy); end
  endtask

  task automatic test_flush();
    iss_ready = 1'b0;
    drive_disp(mk_uop(ALU_ADD, 20, 0, 2, 3), 1'b1, 1, 1'b1, 1);
    tick();
    drive_disp(mk_uop(ALU_ADD, 21, 1, 2, 3), 1'b1, 2, 1'b1, 2);
    tick();
    drive_disp(mk_uop(ALU_ADD, 22, 0, 2, 3), 1'b1, 3, 1'b1, 3);
    tick();
    drive_disp(mk_uop(ALU_ADD, 23, 1, 2, 3), 1'b1, 4, 1'b1, 4);
    tick();
    idle_inputs();
    flush_valid = 1'b1;
    flush_epoch = 2'd1;
    drive_disp(mk_uop(ALU_ADD, 24, 1, 2, 3), 1'b1, 5, 1'b1, 5);
    settle();
    checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL flush_disp_ready: got %0b want 0", disp_ready); end
    checks++; if (iss_uop.rob_idx !== 20) begin failures++; $display("FAIL flush_pre_lock: got %0d want 20", iss_uop.rob_idx); end
    tick();
    idle_inputs();
    settle();
    checks++; if (occupancy !== 2) begin failures++; $display("FAIL flush_occ: got %0d want 2", occupancy); end
    checks++; if (iss_valid !== 1'b1 || iss_uop.rob_idx !== 21) begin failures++; $display("FAIL flush_survivor1: got v %0b rob %0d want rob 21", iss_valid, iss_uop.rob_idx); end
    iss_ready = 1'b1;
    tick();
    checks++; if (iss_uop.rob_idx !== 23) begin failures++; $display("FAIL flush_survivor2: got %0d want 23", iss_uop.rob_idx); end
    tick();
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL flush_occ0: got %0d want 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    iss_ready = 1'b1;
    drive_disp(mk_uop(ALU_ADD, 30, 1, 40, 3), 1'b0, 0, 1'b1, 5);
    drive_wk(40, 555);
    tick();
    idle_inputs();
    settle();
    checks++; if (iss_valid !== 1'b1 || iss_rs1_val !== 555) begin failures++; $display("FAIL disp_wk_capture: got v %0b rs1 %0d want 555", iss_valid, iss_rs1_val); end
    tick();
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL disp_wk_occ: got %0d want 0", occupancy); end
    iss_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_disp(mk_uop(ALU_XOR, k, 1, 2, 3), 1'b1, k, 1'b1, k);
      tick();
    end
    drive_disp(mk_uop(ALU_XOR, 8, 1, 2, 3), 1'b1, 8, 1'b1, 8);
    iss_ready = 1'b1;
    settle();
    checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL full_disp_ready: got %0b want 0", disp_ready); end
    tick();
    checks++; if (occupancy !== 7 || disp_ready !== 1'b1) begin failures++; $display("FAIL full_issue: got occ %0d rdy %0b want 7 1", occupancy, disp_ready); end
    checks++; if (iss_uop.rob_idx !== 1) begin failures++; $display("FAIL full_next: got %0d want 1", iss_uop.rob_idx); end
    tick();
    idle_inputs();
    settle();
    checks++; if (occupancy !== 7) begin failures++; $display("FAIL disp_issue_occ: got %0d want 7", occupancy); end
    for (int k = 2; k <= 8; k++) begin
      checks++; if (iss_valid !== 1'b1 || iss_uop.rob_idx !== ROB_W'(k)) begin failures++; $display("FAIL b2b%0d: got v %0b rob %0d want %0d", k, iss_valid, iss_uop.rob_idx, k); end
      tick();
    end
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL b2b_occ0: got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid_stall();
    iss_ready = 1'b0;
    drive_disp(mk_uop(ALU_AND, 5, 1, 2, 3), 1'b1, 1, 1'b1, 1);
    tick();
    idle_inputs();
    tick();
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL stall_before_reset: got %0b want 1", iss_valid); end
    rst_n = 1'b1;
    settle();
    checks++; if (iss_valid !== 1'b0 || occupancy !== 0) begin failures++; $display("FAIL mid_stall_reset: got v %0b occ %0d want 0 0", iss_valid, occupancy); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (iss_valid !== 1'b0 || disp_ready !== 1'b1) begin failures++; $display("FAIL after_mid_reset: got v %0b rdy %0b want 0 1", iss_valid, disp_ready); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_add();
    test_wakeup();
    test_age();
    test_fill_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
